dphy_lanes_sequencer: RTL and testbench
=======================================

# dphy_lanes_sequencer

Parametrised power and clock sequencer for the MIPI D-PHY TX lanes, driving up to MAX_LANES data lanes plus one clock lane in the clk_phy domain. Sits between the register block / packet FIFOs and the per-lane serialisers. It owns:
- LP buffer enable per active lane;
- clock-lane HS start/stop, in continuous or non-continuous mode, with programmable clk-pre and clk-post intervals;
- the burst grant to the fifo-to-lane bridges.

## Interface
Parameters:
- MAX_LANES, 4: number of data lanes instantiated (1..8).
- CNT_W, $clog2(MAX_LANES)+1: width of reg_lanes_number.

Ports:
- clk_phy  in  1  logic clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- reg_lanes_number  in  CNT_W  active lane count. 0 is treated as 1; values above MAX_LANES are treated as MAX_LANES.
- lines_enable  in  1  level; request LP buffers on.
- clock_enable  in  1  level; permit the HS clock.
- clock_continuous  in  1  1: clock stays HS while enabled. 0: clock runs only around bursts.
- clk_pre_timeout  in  8  cycles from clock-lane active to first grant.
- clk_post_timeout  in  8  cycles from last burst end to clock stop.
- lanes_pending  in  MAX_LANES  per-lane FIFO non-empty.
- lanes_active  in  MAX_LANES  per-lane HS burst in progress.
- lane_ready  in  MAX_LANES+1  per-lane LP-11 reached; bit MAX_LANES is the clock lane.
- clk_lane_active  in  1  clock lane in HS.
- lane_enable  out  MAX_LANES+1  LP buffer enable; bit MAX_LANES is the clock lane.
- lane_grant  out  MAX_LANES  bridge may start a burst.
- clk_start_rqst  out  1  clock lane start request.
- clk_fin_rqst  out  1  clock lane stop request.
- lines_ready  out  1  all enabled lanes in LP-11.
- clock_ready  out  1  clock HS and clk-pre elapsed.
- lines_active  out  1  OR of lanes_active over the active mask.

## Operation
- Lane count and mask:
  - n = clamp(reg_lanes_number, 1, MAX_LANES).
  - n is latched into mask[MAX_LANES-1:0] (low n bits set) on the IDLE->ENABLE transition.
  - The latched mask is held until the block returns to IDLE; reg_lanes_number changes meanwhile are ignored.
- States:
  - IDLE: all outputs 0. Exit to ENABLE when lines_enable=1.
  - ENABLE:
    - lane_enable = {1, mask}.
    - Exit to LP_IDLE when every enabled bit of lane_ready is 1 (AND, not OR).
    - If lines_enable falls here, go to DISABLE.
  - LP_IDLE:
    - lines_ready=1.
    - Go to DISABLE if lines_enable=0.
    - Otherwise go to CLK_START if clock_enable=1 and (clock_continuous=1 or |(lanes_pending&mask)).
  - CLK_START: clk_start_rqst=1. Exit to CLK_PRE when clk_lane_active=1; cnt is loaded with clk_pre_timeout on that transition.
  - CLK_PRE: cnt decrements each cycle. Exit to HS_ACTIVE when cnt==0.
  - HS_ACTIVE:
    - lane_grant=mask, clock_ready=1.
    - Exit to CLK_POST when any of the following holds: clock_enable=0; lines_enable=0; clock_continuous=0 and (lanes_pending|lanes_active)&mask==0.
  - CLK_POST:
    - lane_grant=0, clock_ready=1.
    - cnt is held at clk_post_timeout while |(lanes_active&mask); after that it decrements.
    - Abort back to HS_ACTIVE (cnt untouched) if all of the following hold: clock_enable=1, lines_enable=1, |(lanes_pending&mask), and cnt!=0.
    - Otherwise exit to CLK_STOP when cnt==0 and no lane is active.
  - CLK_STOP: clk_fin_rqst=1. Exit to LP_IDLE when clk_lane_active=0.
  - DISABLE: lane_enable=0. Exit to IDLE when lane_ready&{1,mask}==0.
- lines_active is combinational in every state: |(lanes_active&mask).
- Masked-off lanes never get lane_enable or lane_grant.

## Timing
- Moore outputs are decoded from the registered state, so every output changes 1 cycle after the input edge that caused the transition.
- Reset:
  - rst=1 at an edge forces IDLE, cnt=0, mask=0 and all outputs 0 on the following cycle.
  - This holds even mid-burst or with clk_lane_active=1; the lanes see lane_enable=0 and must self-reset.
- CLK_PRE lasts clk_pre_timeout+1 cycles; a value of 0 still gives 1 cycle.
- CLK_POST lasts clk_post_timeout+1 cycles after the last lanes_active falls.
- Request handshakes:
  - clk_start_rqst is held until clk_lane_active is sampled 1.
  - clk_fin_rqst is held until clk_lane_active is sampled 0.
  - There is no timeout; the lanes guarantee completion.
- Simultaneous events:
  - lines_enable=0 together with a pending burst in LP_IDLE: DISABLE wins.
  - Abort condition and cnt==0 in the same cycle: go to CLK_STOP.
- Continuous mode with clock_enable held: CLK_POST is never entered.

## Test plan
- Bring-up, MAX_LANES=4, reg_lanes_number=2:
  - Assert lines_enable.
  - Expect lane_enable=5'b10011 next cycle.
  - Expect lines_ready=1 exactly one cycle after lane_ready[4,1,0] are all 1; lane_ready[3:2] are ignored.
- Continuous clock, clk_pre_timeout=3:
  - clock_enable=1.
  - clk_start_rqst is held until the model raises clk_lane_active.
  - Then lane_grant=4'b0011 and clock_ready=1 exactly 4 cycles later.
  - Granting persists with lanes_pending=0.
- Non-continuous, clk_post_timeout=5:
  - Pulse lanes_pending[0], then lanes_active[0] for 10 cycles.
  - lane_grant drops when the burst is idle.
  - clk_fin_rqst asserts 6 cycles after lanes_active falls, then the block returns to LP_IDLE.
- Abort in CLK_POST:
  - Raise lanes_pending[1] when cnt=2.
  - Expect return to HS_ACTIVE with lane_grant=0011 and no clk_fin_rqst.
  - With pending raised at cnt==0, expect CLK_STOP instead.
- Clamping: reg_lanes_number=0 gives mask 0001; reg_lanes_number=7 with MAX_LANES=4 gives mask 1111.
- Reset and disable:
  - rst mid-HS_ACTIVE: all outputs 0 next cycle.
  - lines_enable=0 from HS_ACTIVE walks CLK_POST, CLK_STOP, LP_IDLE, DISABLE, IDLE.

Source files
------------

// File: rtl/dphy_lanes_sequencer.sv
// Power and clock-lane sequencer for the D-PHY TX lanes: LP buffer enables,
// clock-lane HS start/stop with clk-pre/clk-post spacing, and burst grants.
module dphy_lanes_sequencer #(
    parameter int MAX_LANES = 4,
    parameter int CNT_W     = $clog2(MAX_LANES) + 1
) (
    input  logic                 clk_phy,
    input  logic                 rst,
    input  logic [CNT_W-1:0]     reg_lanes_number,
    input  logic                 lines_enable,
    input  logic                 clock_enable,
    input  logic                 clock_continuous,
    input  logic [7:0]           clk_pre_timeout,
    input  logic [7:0]           clk_post_timeout,
    input  logic [MAX_LANES-1:0] lanes_pending,
    input  logic [MAX_LANES-1:0] lanes_active,
    input  logic [MAX_LANES:0]   lane_ready,
    input  logic                 clk_lane_active,
    output logic [MAX_LANES:0]   lane_enable,
    output logic [MAX_LANES-1:0] lane_grant,
    output logic                 clk_start_rqst,
    output logic                 clk_fin_rqst,
    output logic                 lines_ready,
    output logic                 clock_ready,
    output logic                 lines_active
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ENABLE,
        S_LP_IDLE,
        S_CLK_START,
        S_CLK_PRE,
        S_HS_ACTIVE,
        S_CLK_POST,
        S_CLK_STOP,
        S_DISABLE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [7:0]           cnt;
    logic [7:0]           cnt_nxt;
    logic [MAX_LANES-1:0] mask;
    logic [MAX_LANES-1:0] mask_nxt;
    logic [MAX_LANES:0]   mask_full;
    logic                 pend;
    logic                 act;
    logic                 all_ready;
    logic                 none_ready;

    // Out-of-range lane counts are clamped into 1..MAX_LANES.
    function automatic logic [MAX_LANES-1:0] count_to_mask(input logic [CNT_W-1:0] num);
        int n;
        logic [MAX_LANES-1:0] m;
        n = int'(num);
        if (n < 1) begin
            n = 1;
        end else if (n > MAX_LANES) begin
            n = MAX_LANES;
        end
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

    assign mask_full    = {1'b1, mask};
    assign pend         = |(lanes_pending & mask);
    assign act          = |(lanes_active & mask);
    assign all_ready    = &(lane_ready | ~mask_full);
    assign none_ready   = ~|(lane_ready & mask_full);
    assign lines_active = act;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mask_nxt  = mask;
        case (state)
            S_IDLE: begin
                if (lines_enable) begin
                    state_nxt = S_ENABLE;
                    mask_nxt  = count_to_mask(reg_lanes_number);
                end
            end
            S_ENABLE: begin
                if (!lines_enable) begin
                    state_nxt = S_DISABLE;
                end else if (all_ready) begin
                    state_nxt = S_LP_IDLE;
                end
            end
            S_LP_IDLE: begin
                if (!lines_enable) begin
                    state_nxt = S_DISABLE;
                end else if (clock_enable && (clock_continuous || pend)) begin
                    state_nxt = S_CLK_START;
                end
            end
            S_CLK_START: begin
                if (clk_lane_active) begin
                    state_nxt = S_CLK_PRE;
                    cnt_nxt   = clk_pre_timeout;
                end
            end
            S_CLK_PRE: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_HS_ACTIVE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_HS_ACTIVE: begin
                if (!clock_enable || !lines_enable || (!clock_continuous && !pend && !act)) begin
                    state_nxt = S_CLK_POST;
                    cnt_nxt   = clk_post_timeout;
                end
            end
            S_CLK_POST: begin
                // A new burst may reclaim the running clock only before the post interval expires.
                if (clock_enable && lines_enable && pend && cnt != 8'd0) begin
                    state_nxt = S_HS_ACTIVE;
                end else if (act) begin
                    cnt_nxt = clk_post_timeout;
                end else if (cnt == 8'd0) begin
                    state_nxt = S_CLK_STOP;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_CLK_STOP: begin
                if (!clk_lane_active) begin
                    state_nxt = S_LP_IDLE;
                end
            end
            S_DISABLE: begin
                if (none_ready) begin
                    state_nxt = S_IDLE;
                    mask_nxt  = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                mask_nxt  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet track the state register.
    always_ff @(posedge clk_phy) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            mask           <= '0;
            lane_enable    <= '0;
            lane_grant     <= '0;
            clk_start_rqst <= 1'b0;
            clk_fin_rqst   <= 1'b0;
            lines_ready    <= 1'b0;
            clock_ready    <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            mask           <= mask_nxt;
            lane_enable    <= (state_nxt == S_IDLE || state_nxt == S_DISABLE) ? '0 : {1'b1, mask_nxt};
            lane_grant     <= (state_nxt == S_HS_ACTIVE) ? mask_nxt : '0;
            clk_start_rqst <= (state_nxt == S_CLK_START);
            clk_fin_rqst   <= (state_nxt == S_CLK_STOP);
            lines_ready    <= (state_nxt == S_LP_IDLE);
            clock_ready    <= (state_nxt == S_HS_ACTIVE || state_nxt == S_CLK_POST);
        end
    end

endmodule

// File: tb/tb_dphy_lanes_sequencer.sv
// Bench for dphy_lanes_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_dphy_lanes_sequencer;

    localparam int ML = 4;
    localparam int CW = 3;

    logic          clk_phy = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] reg_lanes_number = 3'd2;
    logic          lines_enable = 1'b0;
    logic          clock_enable = 1'b0;
    logic          clock_continuous = 1'b0;
    logic [7:0]    clk_pre_timeout = 8'd0;
    logic [7:0]    clk_post_timeout = 8'd0;
    logic [ML-1:0] lanes_pending = '0;
    logic [ML-1:0] lanes_active = '0;
    logic [ML:0]   lane_ready = '0;
    logic          clk_lane_active = 1'b0;
    logic [ML:0]   lane_enable;
    logic [ML-1:0] lane_grant;
    logic          clk_start_rqst;
    logic          clk_fin_rqst;
    logic          lines_ready;
    logic          clock_ready;
    logic          lines_active;

    int n_checks = 0;
    int n_pass = 0;

    dphy_lanes_sequencer #(.MAX_LANES(ML), .CNT_W(CW)) dut (
        .clk_phy(clk_phy), .rst(rst), .reg_lanes_number(reg_lanes_number),
        .lines_enable(lines_enable), .clock_enable(clock_enable),
        .clock_continuous(clock_continuous), .clk_pre_timeout(clk_pre_timeout),
        .clk_post_timeout(clk_post_timeout), .lanes_pending(lanes_pending),
        .lanes_active(lanes_active), .lane_ready(lane_ready),
        .clk_lane_active(clk_lane_active), .lane_enable(lane_enable),
        .lane_grant(lane_grant), .clk_start_rqst(clk_start_rqst),
        .clk_fin_rqst(clk_fin_rqst), .lines_ready(lines_ready),
        .clock_ready(clock_ready), .lines_active(lines_active)
    );

    always #5 clk_phy = ~clk_phy;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", nm, got, want, $time);
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_EN = 1, P_LP = 2, P_CS = 3, P_PRE = 4,
                   P_HS = 5, P_POST = 6, P_STOP = 7, P_DIS = 8;
    int        ph = P_IDLE;
    logic [3:0] mm = '0;
    int        tmr = 0;
    bit        checking = 1'b0;

    function automatic logic [3:0] clamp_mask(input logic [CW-1:0] r);
        int n;
        n = int'(r);
        n = (n < 1) ? 1 : (n > ML ? ML : n);
        return 4'((1 << n) - 1);
    endfunction

    task automatic model_step();
        logic [4:0] need;
        bit pend, act;
        need = {1'b1, mm};
        pend = |(lanes_pending & mm);
        act  = |(lanes_active & mm);
        if (rst) begin
            ph = P_IDLE; mm = '0; tmr = 0; checking = 1'b1;
        end else begin
            case (ph)
                P_IDLE: if (lines_enable) begin ph = P_EN; mm = clamp_mask(reg_lanes_number); end
                P_EN: if (!lines_enable) ph = P_DIS;
                      else if ((lane_ready & need) == need) ph = P_LP;
                P_LP: if (!lines_enable) ph = P_DIS;
                      else if (clock_enable && (clock_continuous || pend)) ph = P_CS;
                P_CS: if (clk_lane_active) begin ph = P_PRE; tmr = int'(clk_pre_timeout); end
                P_PRE: if (tmr == 0) ph = P_HS; else tmr--;
                P_HS: if (!clock_enable || !lines_enable || (!clock_continuous && !pend && !act)) begin
                          ph = P_POST; tmr = int'(clk_post_timeout);
                      end
                P_POST: if (clock_enable && lines_enable && pend && tmr != 0) ph = P_HS;
                        else if (act) tmr = int'(clk_post_timeout);
                        else if (tmr == 0) ph = P_STOP;
                        else tmr--;
                P_STOP: if (!clk_lane_active) ph = P_LP;
                P_DIS: if ((lane_ready & need) == 0) begin ph = P_IDLE; mm = '0; end
                default: ph = P_IDLE;
            endcase
        end
    endtask

    function automatic logic [15:0] expected_outs();
        logic [4:0] le;
        logic [3:0] gr;
        le = (ph == P_IDLE || ph == P_DIS) ? 5'd0 : {1'b1, mm};
        gr = (ph == P_HS) ? mm : 4'd0;
        return {2'b00, le, gr, ph == P_CS, ph == P_STOP, ph == P_LP,
                (ph == P_HS || ph == P_POST), |(lanes_active & mm)};
    endfunction

    function automatic logic [15:0] dut_outs();
        return {2'b00, lane_enable, lane_grant, clk_start_rqst, clk_fin_rqst,
                lines_ready, clock_ready, lines_active};
    endfunction

    initial forever begin
        @(posedge clk_phy);
        model_step();
    end

    initial forever begin
        @(negedge clk_phy);
        if (checking) chk("model_outputs", dut_outs(), expected_outs());
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_phy);
            #1;
        end
    endtask

    // which: 0 grant nonzero, 1 clk_fin_rqst
    task automatic wait_sig(input int which, input int limit);
        bit hit = 1'b0;
        for (int k = 0; k < limit && !hit; k++) begin
            hit = (which == 0) ? (lane_grant != 0) : clk_fin_rqst;
            if (!hit) step();
        end
        n_checks++;
        if (hit) n_pass++;
        else $display("FAIL wait_%0d: condition not seen within %0d cycles", which, limit);
    endtask

    initial begin
        step(2);
        chk("reset_outputs", dut_outs(), 16'h0);
        rst = 1'b0;

        // bring-up with two lanes
        lines_enable = 1'b1;
        step();
        chk("bringup_lane_enable", 16'(lane_enable), 16'h13);
        lane_ready = 5'b01101;
        step();
        chk("lines_ready_partial", 16'(lines_ready), 16'h0);
        lane_ready = 5'b10011;
        step();
        chk("lines_ready_all", 16'(lines_ready), 16'h1);

        // continuous clock, clk_pre 3
        clk_pre_timeout = 8'd3; clk_post_timeout = 8'd5;
        clock_continuous = 1'b1; clock_enable = 1'b1;
        step();
        chk("start_rqst", 16'(clk_start_rqst), 16'h1);
        step(3);
        chk("start_rqst_held", 16'(clk_start_rqst), 16'h1);
        clk_lane_active = 1'b1;
        step();
        chk("start_rqst_dropped", 16'(clk_start_rqst), 16'h0);
        step(3);
        chk("grant_during_pre", 16'(lane_grant), 16'h0);
        step();
        chk("grant_after_pre", 16'(lane_grant), 16'h3);
        chk("clock_ready_hs", 16'(clock_ready), 16'h1);
        step(5);
        chk("grant_persists", 16'(lane_grant), 16'h3);
        clock_continuous = 1'b0;
        step();
        chk("post_grant_off", {7'd0, lane_grant, clock_ready}, 16'h1);
        wait_sig(1, 20);
        clk_lane_active = 1'b0;
        step();
        chk("back_lp_idle", 16'(lines_ready), 16'h1);

        // non-continuous burst, clk_post 5
        lanes_pending = 4'b0001;
        step();
        clk_lane_active = 1'b1;
        wait_sig(0, 20);
        lanes_active = 4'b0001; lanes_pending = 4'b0000;
        step(10);
        chk("grant_in_burst", 16'(lane_grant), 16'h3);
        chk("lines_active_burst", 16'(lines_active), 16'h1);
        lanes_active = 4'b0000;
        step();
        chk("burst_end_grant", {7'd0, lane_grant, clock_ready}, 16'h1);
        step(5);
        chk("fin_not_yet", 16'(clk_fin_rqst), 16'h0);
        step();
        chk("fin_after_post", 16'(clk_fin_rqst), 16'h1);
        clk_lane_active = 1'b0;
        step();
        chk("lp_after_stop", 16'(lines_ready), 16'h1);

        // abort in CLK_POST at cnt 2, then pending at cnt 0
        lanes_pending = 4'b0001;
        step();
        clk_lane_active = 1'b1;
        wait_sig(0, 20);
        lanes_pending = 4'b0000;
        step(4);
        lanes_pending = 4'b0010;
        step();
        chk("abort_grant", {11'd0, lane_grant, clk_fin_rqst}, 16'h6);
        lanes_pending = 4'b0000;
        step(6);
        lanes_pending = 4'b0010;
        step();
        chk("no_abort_at_zero", {11'd0, lane_grant, clk_fin_rqst}, 16'h1);
        lanes_pending = 4'b0000; clk_lane_active = 1'b0;
        step();

        // clamping
        lines_enable = 1'b0;
        step();
        chk("disable_lane_enable", 16'(lane_enable), 16'h0);
        lane_ready = '0;
        step();
        reg_lanes_number = 3'd0; lines_enable = 1'b1;
        step();
        chk("clamp_zero", 16'(lane_enable), 16'h11);
        reg_lanes_number = 3'd7;
        step();
        chk("mask_latched", 16'(lane_enable), 16'h11);
        lines_enable = 1'b0;
        step(2);
        lines_enable = 1'b1;
        step();
        chk("clamp_seven", 16'(lane_enable), 16'h1f);
        lane_ready = 5'b11111;
        step();

        // disable walk from HS_ACTIVE
        lanes_pending = 4'b0001;
        step();
        clk_lane_active = 1'b1;
        wait_sig(0, 20);
        chk("grant_four_lanes", 16'(lane_grant), 16'hf);
        lines_enable = 1'b0;
        step();
        chk("disable_to_post", {7'd0, lane_grant, clock_ready}, 16'h1);
        lanes_pending = 4'b0000;
        wait_sig(1, 20);
        clk_lane_active = 1'b0;
        step();
        chk("disable_walk_lp", 16'(lines_ready), 16'h1);
        step();
        chk("disable_walk_dis", {11'd0, lane_enable}, 16'h0);
        lane_ready = '0;
        step();
        chk("disable_walk_idle", dut_outs(), 16'h0);

        // reset mid-burst
        reg_lanes_number = 3'd2; lines_enable = 1'b1;
        step();
        lane_ready = 5'b11111;
        step();
        lanes_pending = 4'b0001;
        step();
        clk_lane_active = 1'b1;
        wait_sig(0, 20);
        lanes_active = 4'b0001;
        step();
        chk("lines_active_pre_rst", 16'(lines_active), 16'h1);
        rst = 1'b1;
        step();
        chk("reset_mid_hs", dut_outs(), 16'h0);
        rst = 1'b0; lines_enable = 1'b0; clk_lane_active = 1'b0;
        lanes_active = '0; lanes_pending = '0; lane_ready = '0;
        step(2);

        // randomized traffic with a responsive lane environment
        clock_enable = 1'b1;
        repeat (4000) begin
            step();
            rst = ($urandom_range(0, 799) == 0);
            for (int i = 0; i <= ML; i++)
                if (lane_ready[i] != lane_enable[i] && $urandom_range(0, 2) == 0)
                    lane_ready[i] = lane_enable[i];
            if (clk_start_rqst && $urandom_range(0, 3) == 0) clk_lane_active = 1'b1;
            if (clk_fin_rqst && $urandom_range(0, 3) == 0) clk_lane_active = 1'b0;
            if ($urandom_range(0, 199) == 0) lines_enable = ~lines_enable;
            if ($urandom_range(0, 9) == 0 && !lines_enable) lines_enable = 1'b1;
            if ($urandom_range(0, 149) == 0) clock_enable = ~clock_enable;
            if ($urandom_range(0, 99) == 0) clock_continuous = ~clock_continuous;
            if ($urandom_range(0, 49) == 0) begin
                clk_pre_timeout = 8'($urandom_range(0, 5));
                clk_post_timeout = 8'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 29) == 0) reg_lanes_number = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) lanes_pending = 4'($urandom);
            if ($urandom_range(0, 5) == 0) lanes_active = 4'($urandom) & 4'($urandom);
        end
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
